i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
Parametrised successor to the read-only I2C slave plus ROM pair. It is a self-contained I2C target with an internal read/write register file. The register file has configurable depth, 1- or 2-byte word addressing, auto-increment with wrap-around, and repeated-START support. It also provides a fabric-side read port and a per-byte write notification, so user logic can consume values the I2C master writes.

Parameters:
DEV_ADDR, 7'h50, 7-bit I2C device address matched after START
MEM_ADDR_WIDTH, 8, register file address width (1..16); depth = 2**MEM_ADDR_WIDTH bytes
SYNC_STAGES, 2, synchroniser flops on SCL/SDA (min 2)
SDA_SETUP_DELAY_CYCLES, 3, in_clk cycles from synchronised SCL fall to SDA output change

Ports:
in_clk  input  1  system clock
in_rst_n  input  1  reset; synchronous, active-low
in_scl  input  1  I2C SCL (asynchronous)
in_sda  input  1  I2C SDA pad input (asynchronous)
out_sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
out_busy  output  1  high from address-matched START until STOP
in_host_addr  input  MEM_ADDR_WIDTH  fabric read address
out_host_data  output  8  register file data at in_host_addr, 1-cycle latency
out_wr_strobe  output  1  1-cycle pulse per byte written by I2C
out_wr_addr  output  MEM_ADDR_WIDTH  address of written byte (valid with strobe)
out_wr_data  output  8  written byte (valid with strobe)

Behaviour:
- Reset values, applied at in_clk edge while in_rst_n=0:
  - all outputs 0
  - state IDLE, pointer 0, synchroniser flops 1
  - register file contents are not reset
- Input conditioning: SCL/SDA pass through SYNC_STAGES flops, then edge detect.
  - START: SDA fall while SCL high.
  - STOP: SDA rise while SCL high.
  - Both are detected in every state. STOP has priority and forces IDLE.
- Sampling and driving: data sampled on SCL rise. out_sda_oe updates exactly SDA_SETUP_DELAY_CYCLES cycles after SCL fall.
- Address bytes: ADDR_BYTES = 1 if MEM_ADDR_WIDTH<=8, else 2 (high byte first). Unused high bits are ignored.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, WADDR, WADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - IDLE -START-> DEV_ADDR; shift in 8 bits.
  - On device address match: DEV_ACK drives ACK.
    - R/W=0 goes to WADDR.
    - R/W=1 goes to RD_DATA.
  - On mismatch: return to IDLE with SDA released; out_busy stays 0.
  - WADDR: after each address byte, ACK. Pointer loads after the last byte, then go to WR_DATA.
  - WR_DATA: after 8 bits, write mem[pointer], pulse out_wr_strobe once, ACK in WR_ACK, pointer+1.
  - RD_DATA: present mem[pointer] MSB first; pointer+1 after the byte. In RD_ACK, sample the master's bit:
    - ACK (0) continues to RD_DATA.
    - NACK (1) releases SDA and waits in IDLE-equivalent until STOP/START.
- Pointer: wraps from 2**MEM_ADDR_WIDTH-1 to 0. It persists across transactions and repeated STARTs, so write-address-then-Sr-read works.
- Repeated START in any non-IDLE state: go to DEV_ADDR, bit counter cleared, SDA released.
- Simultaneous events:
  - An I2C write and a host read of the same address in the same cycle return the old data.
  - out_wr_strobe and the memory write occur in the same cycle.
- Reset mid-transfer aborts immediately: SDA released, no strobe.

Optional Feature:
Macro I2C_SLAVE_WRITE_PROTECT_EN.
- Defined: adds input port in_wp (1 bit). While in_wp=1, data bytes in WR_DATA are not written and not strobed, and WR_ACK returns NACK (SDA released). The address phase is unaffected.
- Undefined: no in_wp port; all writes are accepted.

Decomposition:
- Package i2c_slave_pkg holds:
  - FSM state enum
  - ACK/NACK constants
  - helper function for ADDR_BYTES from MEM_ADDR_WIDTH
- Sub-module i2c_bus_monitor holds:
  - synchronisers
  - SCL rise/fall strobes
  - START/STOP pulses
  - this block is reused by future I2C targets.
- Register file is inferred inline; it is not a separate module.

Test Plan:
- Write 0x50, addr 0x10, data 0xA5, 0x5A, STOP -> ACK on every byte; two strobes (0x10/0xA5, 0x11/0x5A); host read of 0x11 returns 0x5A one cycle later.
- Write addr 0x10, Sr, read 0x50|R, 2 bytes (ACK, then NACK) -> SDA returns 0xA5, 0x5A; SDA released after NACK.
- Device address 0x51 -> no ACK (SDA stays released), out_busy=0, no strobe.
- Write at address 0xFF, data 0x11, 0x22 -> writes land at 0xFF then 0x00 (wrap).
- MEM_ADDR_WIDTH=10, address bytes 0x03, 0xFE, data 0x77 -> strobe with addr 0x3FE, data 0x77.
- With I2C_SLAVE_WRITE_PROTECT_EN and in_wp=1, write 0x10:0x99 -> data byte NACKed, no strobe, mem[0x10] unchanged. Separately, in_rst_n low mid-byte -> out_sda_oe=0 on the next edge.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and helpers for the I2C target family: FSM states, ACK/NACK
// bit levels and the address-byte count derived from the register file width.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic int addr_bytes(input int mem_addr_width);
    return (mem_addr_width <= 8) ? 1 : 2;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA into the clk domain and derives SCL edge strobes plus
// START/STOP condition pulses. Synchroniser flops reset to the idle-bus level.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] scl_sync_reg;
  logic [STAGES-1:0] sda_sync_reg;
  logic              scl_prev_reg;
  logic              sda_prev_reg;
  logic              scl_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[STAGES-2:0], sda};
      scl_prev_reg <= scl_level;
      sda_prev_reg <= sda_level;
    end
  end

  assign scl_level = scl_sync_reg[STAGES-1];
  assign sda_level = sda_sync_reg[STAGES-1];

  assign scl_rise  = scl_level & ~scl_prev_reg;
  assign scl_fall  = ~scl_level & scl_prev_reg;
  // SDA may only toggle while SCL is high for START/STOP
  assign start_det = scl_level & scl_prev_reg & sda_prev_reg & ~sda_level;
  assign stop_det  = scl_level & scl_prev_reg & ~sda_prev_reg & sda_level;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal read/write register file, auto-increment pointer,
// fabric read port and write notification. Optional write protect: I2C_SLAVE_WRITE_PROTECT_EN.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR               = 7'h50,
  parameter int         MEM_ADDR_WIDTH         = 8,
  parameter int         SYNC_STAGES            = 2,
  parameter int         SDA_SETUP_DELAY_CYCLES = 3
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
  input  logic                      in_wp,
`endif
  input  logic                      in_scl,
  input  logic                      in_sda,
  output logic                      out_sda_oe,
  output logic                      out_busy,
  input  logic [MEM_ADDR_WIDTH-1:0] in_host_addr,
  output logic [7:0]                out_host_data,
  output logic                      out_wr_strobe,
  output logic [MEM_ADDR_WIDTH-1:0] out_wr_addr,
  output logic [7:0]                out_wr_data
);

  localparam int   ADDR_BYTES    = addr_bytes(MEM_ADDR_WIDTH);
  localparam logic LAST_ADDR_IDX = 1'(ADDR_BYTES - 1);
  localparam int   DEPTH         = 1 << MEM_ADDR_WIDTH;
  localparam int   DLY_W         = $clog2(SDA_SETUP_DELAY_CYCLES + 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SDA_SETUP_DELAY_CYCLES);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  logic sda_level, scl_rise, scl_fall, start_det, stop_det;
  logic wp_active;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk      (in_clk),
    .rst_n    (in_rst_n),
    .scl      (in_scl),
    .sda      (in_sda),
    .sda_level(sda_level),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

`ifdef I2C_SLAVE_WRITE_PROTECT_EN
  assign wp_active = in_wp;
`else
  assign wp_active = 1'b0;
`endif

  state_t                    state_reg, state_next;
  logic [2:0]                bit_cnt_reg, bit_cnt_next;
  logic [7:0]                shift_reg, shift_next;
  logic [7:0]                tx_reg, tx_next;
  logic [MEM_ADDR_WIDTH-1:0] pointer_reg, pointer_next;
  logic [7:0]                addr_hi_reg, addr_hi_next;
  logic                      addr_idx_reg, addr_idx_next;
  logic                      busy_reg, busy_next;
  logic                      nack_reg, nack_next;
  logic                      pending_reg, pending_next;
  logic [DLY_W-1:0]          dly_reg, dly_next;
  logic                      sda_oe_reg, sda_oe_next;
  logic                      wr_strobe_reg, wr_strobe_next;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]                wr_data_reg, wr_data_next;

  logic [7:0]  mem [0:DEPTH-1];
  logic [7:0]  rd_data_reg;
  logic [7:0]  host_data_reg;
  logic        mem_we;
  logic [7:0]  rx_byte;
  logic [15:0] addr_full;
  logic        drive_bit;

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    tx_next        = tx_reg;
    pointer_next   = pointer_reg;
    addr_hi_next   = addr_hi_reg;
    addr_idx_next  = addr_idx_reg;
    busy_next      = busy_reg;
    nack_next      = nack_reg;
    pending_next   = pending_reg;
    dly_next       = dly_reg;
    sda_oe_next    = sda_oe_reg;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    mem_we         = 1'b0;
    drive_bit      = NACK;
    rx_byte        = {shift_reg[6:0], sda_level};
    addr_full      = {addr_hi_reg, rx_byte};

    // Bit chosen at SCL fall reaches the pad after the setup delay
    if (dly_reg != '0) begin
      dly_next = dly_reg - DLY_ONE;
      if (dly_reg == DLY_ONE) sda_oe_next = pending_reg;
    end

    if (stop_det) begin
      state_next   = ST_IDLE;
      busy_next    = 1'b0;
      bit_cnt_next = '0;
      dly_next     = '0;
      sda_oe_next  = 1'b0;
    end else if (start_det) begin
      state_next   = ST_DEV_ADDR;
      bit_cnt_next = '0;
      dly_next     = '0;
      sda_oe_next  = 1'b0;
    end else if (scl_rise) begin
      case (state_reg)
        ST_DEV_ADDR, ST_WADDR, ST_WR_DATA: begin
          shift_next   = rx_byte;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (state_reg == ST_DEV_ADDR) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_next = ST_DEV_ACK;
                busy_next  = 1'b1;
              end else begin
                state_next = ST_IDLE;
              end
            end else if (state_reg == ST_WADDR) begin
              addr_hi_next = rx_byte;
              if (addr_idx_reg == LAST_ADDR_IDX) pointer_next = MEM_ADDR_WIDTH'(addr_full);
              state_next = ST_WADDR_ACK;
            end else begin
              state_next = ST_WR_ACK;
              nack_next  = wp_active;
              if (!wp_active) begin
                mem_we         = 1'b1;
                wr_strobe_next = 1'b1;
                wr_addr_next   = pointer_reg;
                wr_data_next   = rx_byte;
                pointer_next   = pointer_reg + 1'b1;
              end
            end
          end
        end
        ST_DEV_ACK: begin
          if (shift_reg[0]) begin
            state_next = ST_RD_DATA;
            tx_next    = rd_data_reg;
          end else begin
            state_next    = ST_WADDR;
            addr_idx_next = 1'b0;
          end
        end
        ST_WADDR_ACK: begin
          if (addr_idx_reg == LAST_ADDR_IDX) begin
            state_next = ST_WR_DATA;
          end else begin
            state_next    = ST_WADDR;
            addr_idx_next = 1'b1;
          end
        end
        ST_WR_ACK: state_next = ST_WR_DATA;
        ST_RD_DATA: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next   = ST_RD_ACK;
            pointer_next = pointer_reg + 1'b1;
          end
        end
        ST_RD_ACK: begin
          if (sda_level == ACK) begin
            state_next = ST_RD_DATA;
            tx_next    = rd_data_reg;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_reg)
        ST_DEV_ACK, ST_WADDR_ACK: drive_bit = ACK;
        ST_WR_ACK:                drive_bit = nack_reg ? NACK : ACK;
        ST_RD_DATA: begin
          drive_bit = tx_reg[7];
          tx_next   = {tx_reg[6:0], 1'b0};
        end
        default:                  drive_bit = NACK;
      endcase
      pending_next = (drive_bit == ACK);
      dly_next     = DLY_LOAD;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      pointer_reg   <= '0;
      addr_hi_reg   <= '0;
      addr_idx_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      nack_reg      <= 1'b0;
      pending_reg   <= 1'b0;
      dly_reg       <= '0;
      sda_oe_reg    <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      pointer_reg   <= pointer_next;
      addr_hi_reg   <= addr_hi_next;
      addr_idx_reg  <= addr_idx_next;
      busy_reg      <= busy_next;
      nack_reg      <= nack_next;
      pending_reg   <= pending_next;
      dly_reg       <= dly_next;
      sda_oe_reg    <= sda_oe_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  // Registered reads return pre-write contents on a same-address collision
  always_ff @(posedge in_clk) begin
    if (mem_we && in_rst_n) mem[pointer_reg] <= rx_byte;
    rd_data_reg <= mem[pointer_reg];
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) host_data_reg <= '0;
    else           host_data_reg <= mem[in_host_addr];
  end

  assign out_sda_oe    = sda_oe_reg;
  assign out_busy      = busy_reg;
  assign out_host_data = host_data_reg;
  assign out_wr_strobe = wr_strobe_reg;
  assign out_wr_addr   = wr_addr_reg;
  assign out_wr_data   = wr_data_reg;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: a bit-banged I2C master drives two targets (8-bit and 10-bit
// address widths) on one open-drain bus and checks ACKs, read data and strobes.
module tb_i2c_slave_regfile;

    localparam int  T       = 200;
    localparam int  HOLD    = 20;
    localparam time TIMEOUT = 5ms;

    logic clk;
    logic rst_n;
    logic scl_m, sda_m;
    logic [7:0] host_addr_a;
    logic [9:0] host_addr_b;
    logic oe_a, oe_b, busy_a, busy_b, strobe_a, strobe_b;
    logic [7:0] host_data_a, host_data_b, wr_data_a, wr_data_b;
    logic [7:0] wr_addr_a;
    logic [9:0] wr_addr_b;
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
    logic wp;
`endif

    wire sda_bus = sda_m & ~oe_a & ~oe_b;

    int checks = 0;
    int failures = 0;
    logic [15:0] strobes_a[$];
    logic [17:0] strobes_b[$];
    logic ack;
    logic [7:0] rbyte;
    logic [7:0] dev_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s observed=%0h", tag, obs);
        end
    endtask

    i2c_slave_regfile #(
        .DEV_ADDR(7'h50), .MEM_ADDR_WIDTH(8), .SYNC_STAGES(2), .SDA_SETUP_DELAY_CYCLES(3)
    ) dut_a (
        .in_clk(clk), .in_rst_n(rst_n),
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
        .in_wp(wp),
`endif
        .in_scl(scl_m), .in_sda(sda_bus), .out_sda_oe(oe_a), .out_busy(busy_a),
        .in_host_addr(host_addr_a), .out_host_data(host_data_a),
        .out_wr_strobe(strobe_a), .out_wr_addr(wr_addr_a), .out_wr_data(wr_data_a)
    );

    i2c_slave_regfile #(
        .DEV_ADDR(7'h3A), .MEM_ADDR_WIDTH(10), .SYNC_STAGES(2), .SDA_SETUP_DELAY_CYCLES(3)
    ) dut_b (
        .in_clk(clk), .in_rst_n(rst_n),
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
        .in_wp(1'b0),
`endif
        .in_scl(scl_m), .in_sda(sda_bus), .out_sda_oe(oe_b), .out_busy(busy_b),
        .in_host_addr(host_addr_b), .out_host_data(host_data_b),
        .out_wr_strobe(strobe_b), .out_wr_addr(wr_addr_b), .out_wr_data(wr_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (strobe_a) strobes_a.push_back({wr_addr_a, wr_data_a});
        if (strobe_b) strobes_b.push_back({wr_addr_b, wr_data_b});
    end

    initial begin
        #(TIMEOUT);
        failures++;
        $error("FAIL timeout expired after %0t", TIMEOUT);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic i2c_start();
        sda_m = 1'b0; #(T); scl_m = 1'b0; #(HOLD);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; #(T); scl_m = 1'b1; #(T); sda_m = 1'b0; #(T); scl_m = 1'b0; #(HOLD);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(T); scl_m = 1'b1; #(T); sda_m = 1'b1; #(T);
    endtask

    task automatic send_bit(input logic v);
        sda_m = v; #(T); scl_m = 1'b1; #(T); scl_m = 1'b0; #(HOLD);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #(T); scl_m = 1'b1; #(T/2);
        acked = ~sda_bus;
        #(T/2); scl_m = 1'b0; #(HOLD);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #(T); scl_m = 1'b1; #(T/2);
            b[i] = sda_bus;
            #(T/2); scl_m = 1'b0; #(HOLD);
        end
        send_bit(master_ack ? 1'b0 : 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        host_addr_a = 8'h00; host_addr_b = 10'h000;
        dev_byte = 8'hA0;
`ifdef I2C_SLAVE_WRITE_PROTECT_EN
        wp = 1'b0;
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", oe_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_strobe", strobe_a, 1'b0);
        check("rst_wr_addr", wr_addr_a, 8'h00);
        check("rst_wr_data", wr_data_a, 8'h00);
        check("rst_host_data", host_data_a, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        strobes_a.delete();
        i2c_start();
        send_byte(8'hA0, ack); check("w1_dev_ack", ack, 1'b1);
        check("w1_busy", busy_a, 1'b1);
        send_byte(8'h10, ack); check("w1_addr_ack", ack, 1'b1);
        send_byte(8'hA5, ack); check("w1_data0_ack", ack, 1'b1);
        send_byte(8'h5A, ack); check("w1_data1_ack", ack, 1'b1);
        i2c_stop();
        check("w1_busy_after_stop", busy_a, 1'b0);
        check("w1_strobe_count", strobes_a.size(), 2);
        check("w1_strobe0", strobes_a[0], 16'h10A5);
        check("w1_strobe1", strobes_a[1], 16'h115A);
        @(negedge clk) host_addr_a = 8'h11;
        @(posedge clk); @(negedge clk);
        check("w1_host_read_11", host_data_a, 8'h5A);

        i2c_start();
        send_byte(8'hA0, ack); check("r1_dev_ack", ack, 1'b1);
        send_byte(8'h10, ack); check("r1_addr_ack", ack, 1'b1);
        i2c_rstart();
        send_byte(8'hA1, ack); check("r1_dev_rd_ack", ack, 1'b1);
        recv_byte(1'b1, rbyte); check("r1_byte0", rbyte, 8'hA5);
        recv_byte(1'b0, rbyte); check("r1_byte1", rbyte, 8'h5A);
        #(T);
        check("r1_released_after_nack", oe_a, 1'b0);
        i2c_stop();

        strobes_a.delete();
        i2c_start();
        send_byte(8'hA2, ack); check("nm_no_ack", ack, 1'b0);
        check("nm_busy", busy_a, 1'b0);
        check("nm_sda_oe", oe_a, 1'b0);
        i2c_stop();
        check("nm_strobe_count", strobes_a.size(), 0);

        strobes_a.delete();
        i2c_start();
        send_byte(8'hA0, ack); check("wr_dev_ack", ack, 1'b1);
        send_byte(8'hFF, ack); check("wr_addr_ack", ack, 1'b1);
        send_byte(8'h11, ack); check("wr_data0_ack", ack, 1'b1);
        send_byte(8'h22, ack); check("wr_data1_ack", ack, 1'b1);
        i2c_stop();
        check("wr_strobe_count", strobes_a.size(), 2);
        check("wr_strobe0", strobes_a[0], 16'hFF11);
        check("wr_strobe1", strobes_a[1], 16'h0022);
        @(negedge clk) host_addr_a = 8'h00;
        @(posedge clk); @(negedge clk);
        check("wr_host_read_00", host_data_a, 8'h22);

        strobes_a.delete();
        strobes_b.delete();
        i2c_start();
        send_byte(8'h74, ack); check("w10_dev_ack", ack, 1'b1);
        send_byte(8'h03, ack); check("w10_addr_hi_ack", ack, 1'b1);
        send_byte(8'hFE, ack); check("w10_addr_lo_ack", ack, 1'b1);
        send_byte(8'h77, ack); check("w10_data_ack", ack, 1'b1);
        i2c_stop();
        check("w10_strobe_count", strobes_b.size(), 1);
        check("w10_strobe0", strobes_b[0], 18'h3FE77);
        check("w10_other_target_quiet", strobes_a.size(), 0);
        @(negedge clk) host_addr_b = 10'h3FE;
        @(posedge clk); @(negedge clk);
        check("w10_host_read_3fe", host_data_b, 8'h77);

`ifdef I2C_SLAVE_WRITE_PROTECT_EN
        strobes_a.delete();
        wp = 1'b1;
        i2c_start();
        send_byte(8'hA0, ack); check("wp_dev_ack", ack, 1'b1);
        send_byte(8'h10, ack); check("wp_addr_ack", ack, 1'b1);
        send_byte(8'h99, ack); check("wp_data_nack", ack, 1'b0);
        i2c_stop();
        wp = 1'b0;
        check("wp_strobe_count", strobes_a.size(), 0);
        @(negedge clk) host_addr_a = 8'h10;
        @(posedge clk); @(negedge clk);
        check("wp_mem_unchanged", host_data_a, 8'hA5);
`endif

        strobes_a.delete();
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(dev_byte[i]);
        sda_m = 1'b1; #(T);
        check("rst_mid_ack_driven", oe_a, 1'b1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_sda_released", oe_a, 1'b0);
        check("rst_mid_busy", busy_a, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        i2c_stop();
        check("rst_mid_strobe_count", strobes_a.size(), 0);

        i2c_start();
        send_byte(8'hA1, ack); check("rp_dev_ack", ack, 1'b1);
        recv_byte(1'b0, rbyte); check("rp_byte_mem0", rbyte, 8'h22);
        i2c_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
